uart_tx_fifo_reader: RTL and testbench

- Consumer end of a transmit FIFO: pops bytes and serialises each one as an asynchronous UART frame on `tx`.
- Frame format is 1 start bit, DBIT data bits LSB-first, an optional even-parity bit, and stop bits.
- Sits between the transmit FIFO and the pin, and is paced by the shared 16× oversampling baud tick.
- Runs continuously: back-to-back frames go out while the FIFO has data, with no CPU involvement.

---
 rtl/uart_tx_fifo_reader_if.sv | 25 ++
 rtl/uart_tx_fifo_reader.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_reader_if.sv
// FIFO read-side bundle for uart_tx_fifo_reader.
// Handshake: fifo_empty=0 means fifo_r_data is valid (combinationally).
// fifo_rd is the one-clk pop strobe. A word is consumed on the rising edge
// where fifo_rd=1. The master never raises fifo_rd while fifo_empty=1.
interface uart_tx_fifo_reader_if #(
  parameter int DBIT = 8
);
  logic            fifo_empty;
  logic [DBIT-1:0] fifo_r_data;
  logic            fifo_rd;

  // Transmitter side: pops words.
  modport master (
    input  fifo_empty,
    input  fifo_r_data,
    output fifo_rd
  );

  // FIFO side: supplies words.
  modport slave (
    output fifo_empty,
    output fifo_r_data,
    input  fifo_rd
  );
endinterface

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that drains a transmit FIFO.
// Frame: 1 start bit, DBIT data bits LSB first, optional even-parity bit,
// then SB_TICK ticks of stop. Paced by a 16x oversampling s_tick.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state and p_reg.
// dbg_state exposes the FSM state encoding for observation.
module uart_tx_fifo_reader #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_tick,
  uart_tx_fifo_reader_if.master         fifo,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done_tick,
  output logic [2:0]                    dbg_state
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  state_t          state_reg, state_next;
  logic [4:0]      s_reg, s_next;
  logic [2:0]      n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            tx_reg, tx_next;
  logic            pop_c, done_c;
`ifdef UART_TX_PARITY_EN
  logic            p_reg, p_next;
`endif

  // State and datapath registers; synchronous active-low reset returns the line high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      p_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
`ifdef UART_TX_PARITY_EN
      p_reg     <= p_next;
`endif
    end
  end

  // Next-state logic; counters and state move only on s_tick, except the IDLE pop.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    pop_c      = 1'b0;
    done_c     = 1'b0;
`ifdef UART_TX_PARITY_EN
    p_next     = p_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!fifo.fifo_empty) begin
          b_next     = fifo.fifo_r_data;
          pop_c      = 1'b1;
          s_next     = '0;
`ifdef UART_TX_PARITY_EN
          p_next     = 1'b0;
`endif
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            n_next = n_reg + 3'd1;
`ifdef UART_TX_PARITY_EN
            p_next = p_reg ^ b_reg[0];
            if (n_reg == N_LAST) state_next = PARITY;
`else
            if (n_reg == N_LAST) state_next = STOP;
`endif
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_reg == STOP_LAST) begin
            s_next     = '0;
            done_c     = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level is computed from the state being entered so tx changes on the same edge.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = p_next;
`endif
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  // Strobes are masked by reset so a held reset never pops or completes a frame.
  assign fifo.fifo_rd = pop_c & reset;
  assign tx_done_tick = done_c & reset;
  assign tx_busy      = (state_reg != IDLE);
  assign tx           = tx_reg;
  assign dbg_state    = state_reg;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader: two instances (SB_TICK 16 and 32)
// fed by small FIFO models, s_tick every 4 clocks.
module tb_uart_tx_fifo_reader;
  localparam int DBIT = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME16 = 4 * ((1 + DBIT + P) * 16 + 16);
  localparam int FRAME32 = 4 * ((1 + DBIT + P) * 16 + 32);
  localparam int ST_IDLE  = 0;
  localparam int ST_START = 1;
  localparam int ST_DATA  = 2;

  // ---------------- clock / reset / tick ----------------
  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       tick_en = 1'b0;
  logic [1:0] div     = 2'd0;
  logic       s_tick;
  logic       tick_q  = 1'b0;
  int         cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 2'd1;
  assign s_tick = tick_en & (div == 2'd3);
  always @(posedge clk) tick_q <= s_tick;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- FIFO models ----------------
  uart_tx_fifo_reader_if #(.DBIT(DBIT)) fif0 ();
  uart_tx_fifo_reader_if #(.DBIT(DBIT)) fif1 ();

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic [3:0] wr0 = 4'd0, rd0 = 4'd0, wr1 = 4'd0, rd1 = 4'd0;
  int         dones0 = 0, dones1 = 0;

  assign fif0.fifo_empty  = (wr0 == rd0);
  assign fif0.fifo_r_data = mem0[rd0];
  assign fif1.fifo_empty  = (wr1 == rd1);
  assign fif1.fifo_r_data = mem1[rd1];

  always @(posedge clk) begin
    if (fif0.fifo_rd === 1'b1 && wr0 != rd0) rd0 <= rd0 + 4'd1;
    if (fif1.fifo_rd === 1'b1 && wr1 != rd1) rd1 <= rd1 + 4'd1;
  end

  // ---------------- DUTs ----------------
  logic       tx0, busy0, done0, tx1, busy1, done1;
  logic [2:0] st0, st1;

  uart_tx_fifo_reader #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .fifo(fif0),
    .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0), .dbg_state(st0)
  );

  uart_tx_fifo_reader #(.DBIT(DBIT), .SB_TICK(32)) dut32 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .fifo(fif1),
    .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1), .dbg_state(st1)
  );

  always @(posedge clk) begin
    if (done0 === 1'b1) dones0 <= dones0 + 1;
    if (done1 === 1'b1) dones1 <= dones1 + 1;
  end

  // Selected instance for the shared frame checker.
  int         sel = 0;
  logic       c_tx, c_busy, c_done, c_rd, c_empty;
  logic [2:0] c_st;
  assign c_tx    = (sel == 0) ? tx0   : tx1;
  assign c_busy  = (sel == 0) ? busy0 : busy1;
  assign c_done  = (sel == 0) ? done0 : done1;
  assign c_st    = (sel == 0) ? st0   : st1;
  assign c_rd    = (sel == 0) ? fif0.fifo_rd     : fif1.fifo_rd;
  assign c_empty = (sel == 0) ? fif0.fifo_empty  : fif1.fifo_empty;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int fails  = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // A pop strobe is only legal while the FIFO holds data.
  always @(negedge clk) begin
    if (fif0.fifo_rd === 1'b1) chk1("rd_when_empty0", fif0.fifo_empty, 1'b0);
    if (fif1.fifo_rd === 1'b1) chk1("rd_when_empty1", fif1.fifo_empty, 1'b0);
  end

  // ---------------- driver tasks ----------------
  task automatic push(input int s, input logic [7:0] d);
    if (s == 0) begin
      mem0[wr0] = d;
      wr0 = wr0 + 4'd1;
    end else begin
      mem1[wr1] = d;
      wr1 = wr1 + 4'd1;
    end
  endtask

  // Returns at a falling edge where s_tick is high for the coming rising edge.
  task automatic align_tick();
    int g = 0;
    @(negedge clk);
    while (s_tick !== 1'b1 && g < 8) begin
      @(negedge clk);
      g++;
    end
    if (s_tick !== 1'b1) chkn("align_timeout", g, 0);
  endtask

  // Counts n rising edges that carried s_tick; ends just after a rising edge.
  task automatic wait_ticks(input int n);
    int got = 0;
    int guard = 0;
    while (got < n && guard < n * 8 + 16) begin
      @(posedge clk);
      #1;
      if (tick_q) got++;
      guard++;
    end
    if (got < n) chkn("tick_timeout", got, n);
  endtask

  // Called inside the pop cycle. Checks the whole serial frame of d and the
  // done strobe; exp_len > 0 also checks pop-edge-to-done-edge clock count.
  task automatic frame_body(input logic [7:0] d, input logic par, input int exp_len,
                            input logic exp_empty, input string nm);
    int pop_cyc;
    int g;
    int sbt;
    logic stop_high;
    sbt = (sel == 0) ? 16 : 32;
    chk1({nm, "_pop"}, c_rd, 1'b1);
    chk1({nm, "_busy_pre"}, c_busy, 1'b0);
    @(posedge clk);
    #1;
    pop_cyc = cyc;
    chk1({nm, "_tx_fall"}, c_tx, 1'b0);
    chk1({nm, "_busy"}, c_busy, 1'b1);
    chkn({nm, "_st_start"}, int'(c_st), ST_START);
    chk1({nm, "_empty_after"}, c_empty, exp_empty);
    wait_ticks(8);
    @(negedge clk);
    chk1({nm, "_start_mid"}, c_tx, 1'b0);
    for (int k = 0; k < DBIT; k++) begin
      wait_ticks(16);
      @(negedge clk);
      chk1($sformatf("%s_bit%0d", nm, k), c_tx, d[k]);
    end
    if (P == 1) begin
      wait_ticks(16);
      @(negedge clk);
      chk1({nm, "_parity"}, c_tx, par);
    end
    wait_ticks(8 + sbt / 2);
    @(negedge clk);
    chk1({nm, "_stop_mid"}, c_tx, 1'b1);
    g = 0;
    stop_high = 1'b1;
    while (c_done !== 1'b1 && g < sbt * 4 + 16) begin
      @(negedge clk);
      if (c_tx !== 1'b1) stop_high = 1'b0;
      g++;
    end
    chk1({nm, "_done_seen"}, c_done, 1'b1);
    chk1({nm, "_stop_high"}, stop_high, 1'b1);
    chk1({nm, "_busy_at_done"}, c_busy, 1'b1);
    if (exp_len > 0) chkn({nm, "_len"}, cyc - pop_cyc, exp_len - 1);
    @(posedge clk);
    #1;
    chkn({nm, "_st_idle"}, int'(c_st), ST_IDLE);
    chk1({nm, "_busy_gap"}, c_busy, 1'b0);
    chk1({nm, "_done_pulse"}, c_done, 1'b0);
    chk1({nm, "_tx_idle"}, c_tx, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       par;
    string      name;
  } vec_t;

  vec_t vecs [6];

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{8'h07, 1'b1, "v07"};
    vecs[1] = '{8'h03, 1'b0, "v03"};
    vecs[2] = '{8'h00, 1'b0, "v00"};
    vecs[3] = '{8'h80, 1'b1, "v80"};
    vecs[4] = '{8'h5A, 1'b0, "v5a"};
    vecs[5] = '{8'h3E, 1'b1, "v3e"};

    // Reset hold with data waiting.
    sel     = 0;
    reset   = 1'b0;
    tick_en = 1'b1;
    push(0, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1($sformatf("rst_tx%0d", i), tx0, 1'b1);
      chk1($sformatf("rst_rd%0d", i), fif0.fifo_rd, 1'b0);
      chk1($sformatf("rst_busy%0d", i), busy0, 1'b0);
      chk1($sformatf("rst_done%0d", i), done0, 1'b0);
      chkn($sformatf("rst_st%0d", i), int'(st0), ST_IDLE);
      chk1($sformatf("rst_tx32_%0d", i), tx1, 1'b1);
    end

    // Release aligned to a tick: first cycle pops, 0xA5 frame is 640 clocks.
    align_tick();
    reset = 1'b1;
    #1;
    frame_body(8'hA5, 1'b0, FRAME16, 1'b1, "a5");

    // Table-driven single frames.
    for (int i = 0; i < 6; i++) begin
      align_tick();
      push(0, vecs[i].data);
      #1;
      frame_body(vecs[i].data, vecs[i].par, FRAME16, 1'b1, vecs[i].name);
    end

    // Back-to-back: pop one clock after each done, busy low for that clock.
    align_tick();
    push(0, 8'h55);
    push(0, 8'hAA);
    push(0, 8'h0F);
    #1;
    frame_body(8'h55, 1'b0, FRAME16,     1'b0, "b2b0");
    frame_body(8'hAA, 1'b0, FRAME16 - 1, 1'b0, "b2b1");
    frame_body(8'h0F, 1'b0, FRAME16 - 1, 1'b1, "b2b2");

    // Reset in the middle of data bit 3 of 0xFF.
    align_tick();
    push(0, 8'hFF);
    #1;
    chk1("mid_pop", fif0.fifo_rd, 1'b1);
    @(posedge clk);
    #1;
    wait_ticks(8 + 16 * 4);
    @(negedge clk);
    chkn("mid_st_data", int'(st0), ST_DATA);
    chk1("mid_busy", busy0, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk1("mid_rst_tx", tx0, 1'b1);
    chk1("mid_rst_busy", busy0, 1'b0);
    chk1("mid_rst_done", done0, 1'b0);
    chkn("mid_rst_st", int'(st0), ST_IDLE);
    push(0, 8'h12);
    #1;
    chk1("mid_rst_nord", fif0.fifo_rd, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk1($sformatf("mid_hold_rd%0d", i), fif0.fifo_rd, 1'b0);
      chk1($sformatf("mid_hold_done%0d", i), done0, 1'b0);
    end
    align_tick();
    reset = 1'b1;
    #1;
    frame_body(8'h12, 1'b0, FRAME16, 1'b1, "after_rst");

    // Two stop bits on the SB_TICK=32 instance.
    sel = 1;
    align_tick();
    push(1, 8'h00);
    #1;
    frame_body(8'h00, 1'b0, FRAME32, 1'b1, "sb32");

    // Totals: aborted frame issues no done; every pushed word was read once.
    repeat (4) @(negedge clk);
    chkn("done0_count", dones0, 11);
    chkn("done1_count", dones1, 1);
    chkn("fifo0_drained", int'(rd0), int'(wr0));
    chkn("fifo1_drained", int'(rd1), int'(wr1));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
